alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have the following ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  width  requester 0 operands
- req0_op  input  4  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_z  output  width  registered ALU result
- rsp_id  output  1  requester that owns the result
- rsp_err  output  1  opcode was outside 0..8
REQ-003 One clock; reset is asynchronous and active-high (clk, rst).
REQ-004 The block SHALL instantiate exactly one alu #(.width(width)) and SHALL be its only driver.

Function
REQ-005 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-006 IDLE: if any reqN_valid=1, grant one requester, pulse its reqN_ready=1 in the same cycle (combinational from state and valids), capture A/B/op/id into operand registers, and go to EXEC. Otherwise stay in IDLE.
REQ-007 reqN_ready SHALL be 0 in EXEC and RESP, and for the non-granted requester.
REQ-008 At most one reqN_ready SHALL be high in any cycle.
REQ-009 EXEC: drive the captured operands to the ALU for exactly one cycle, register the ALU Z into rsp_z, and go to RESP.
REQ-010 If the captured op > 8: rsp_z SHALL be 0 and rsp_err SHALL be 1. Otherwise rsp_err SHALL be 0.
REQ-011 RESP: rsp_valid=1, and rsp_z/rsp_id/rsp_err SHALL be held stable until rsp_ready=1. rsp_valid && rsp_ready SHALL return the FSM to IDLE.
REQ-012 Latency SHALL be exactly 2 cycles from accept (reqN_valid && reqN_ready) to first rsp_valid. Throughput SHALL be at most one operation per 3 cycles.
REQ-013 A new request SHALL NOT be accepted in the cycle the response completes; it is accepted in the following IDLE cycle.
REQ-014 reqN_valid deasserting while not accepted SHALL drop that request with no side effect.
REQ-015 Operand registers SHALL change only on accept.

Reset
REQ-016 On rst=1 the block SHALL immediately enter IDLE: rsp_valid=0, rsp_z=0, rsp_id=0, rsp_err=0, operand registers=0, priority pointer=0.
REQ-017 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced after reset release.
REQ-018 The first accept SHALL be possible on the first rising clk edge after rst deasserts.

Configuration
REQ-019 Macro ALU_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-020 With ALU_ARBITER_RR_EN defined: round-robin. A 1-bit pointer names the preferred requester and is set to the other requester after each accept. When both requesters are valid, the pointer's requester wins.
REQ-021 With ALU_ARBITER_RR_EN undefined: fixed priority. Requester 0 always wins when both are valid, and no pointer register exists.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single request: req0 A=8'h40, B=8'h03, op=0 -> req0_ready pulse; rsp_valid 2 cycles later; rsp_z = ALU(8'h40, 8'h03, 0); rsp_id=0; rsp_err=0.
- Contention: both requesters valid continuously, ops 1 and 2, rsp_ready=1. With RR_EN: rsp_id sequence 0,1,0,1. Without RR_EN: 0,0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_z stable, both reqN_ready=0. On rsp_ready=1: one-cycle handshake, then IDLE.
- Illegal opcode: req1 op=4'hC, A=8'hFF, B=8'h07 -> rsp_err=1, rsp_z=8'h00, rsp_id=1.
- Reset mid-operation: rst pulsed during EXEC -> rsp_valid stays 0, all outputs 0. Next req0 op=8 completes normally.
- Sweep: ops 0..8, A = 8'h40..8'hFF, B = 0..7 -> every rsp_z matches a standalone ALU model.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE -> EXEC -> RESP handshake.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module alu #(
  parameter int width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [width-1:0] z_o
);

  // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 unsigned less-than, 8 multiply (low half)
  always_comb begin
    z_o = '0;
    case (op_i)
      4'd0: z_o = a_i + b_i;
      4'd1: z_o = a_i - b_i;
      4'd2: z_o = a_i & b_i;
      4'd3: z_o = a_i | b_i;
      4'd4: z_o = a_i ^ b_i;
      4'd5: z_o = a_i << b_i;
      4'd6: z_o = a_i >> b_i;
      4'd7: z_o = {{(width-1){1'b0}}, (a_i < b_i)};
      4'd8: z_o = a_i * b_i;
      default: z_o = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_z,
  output logic             rsp_id,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             id_q;
  logic [width-1:0] rsp_z_q;
  logic             rsp_id_q, rsp_err_q;
  logic             pick1;
  logic             accept;
  logic [width-1:0] alu_z;

`ifdef ALU_ARBITER_RR_EN
  logic ptr_q;

  // Pointer names the preferred requester; it moves to the other side after every accept.
  assign pick1 = req1_valid && (!req0_valid || ptr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= !pick1;
    end
  end
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = !pick1;
          req1_ready = pick1;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= pick1 ? req1_a  : req0_a;
      b_q  <= pick1 ? req1_b  : req0_b;
      op_q <= pick1 ? req1_op : req0_op;
      id_q <= pick1;
    end
  end

  alu #(.width(width)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .z_o  (alu_z)
  );

  // Response registers load only in EXEC, so they hold through any RESP backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_z_q   <= '0;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_z_q   <= (op_q > 4'd8) ? '0 : alu_z;
      rsp_id_q  <= id_q;
      rsp_err_q <= (op_q > 4'd8);
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios, an opcode/operand sweep and random traffic.
// Expected arbitration follows ALU_ARBITER_RR_EN when the bench is built with the same define.

module tb_alu_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [3:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [3:0]   req1_op;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_z;
  logic         rsp_id, rsp_err;

  int   checks = 0;
  int   errors = 0;
  logic mptr   = 1'b0;

  alu_arbiter #(.width(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU computed with integer arithmetic on unsigned operand values.
  function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b + 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b < 8) ? a * (1 << b) : 0;
      6: r = (b < 8) ? a / (1 << b) : 0;
      7: r = (a < b) ? 1 : 0;
      8: r = a * b;
      default: r = 0;
    endcase
    return 8'(r % 256);
  endfunction

  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARBITER_RR_EN
      return int'(mptr);
`else
      return 0;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic txn(input string tag,
                     input logic v0, input int a0, input int b0, input int op0,
                     input logic v1, input int a1, input int b1, input int op1,
                     input int stall);
    int         w, ea, eb, eop;
    logic [7:0] ez;
    logic       eerr;
    req0_valid = v0; req0_a = 8'(a0); req0_b = 8'(b0); req0_op = 4'(op0);
    req1_valid = v1; req1_a = 8'(a1); req1_b = 8'(b1); req1_op = 4'(op1);
    rsp_ready  = 1'b0;
    #1;
    w = pick(v0, v1);
    chk({tag, "_acc_rdy0"}, 32'(req0_ready), 32'(v0 && (w == 0)));
    chk({tag, "_acc_rdy1"}, 32'(req1_ready), 32'(v1 && (w == 1)));
    ea   = (w == 1) ? a1 : a0;
    eb   = (w == 1) ? b1 : b0;
    eop  = (w == 1) ? op1 : op0;
    mptr = (w == 0);
    ez   = alu_ref(ea, eb, eop);
    eerr = (eop > 8);
    @(posedge clk); #1;
    chk({tag, "_exec_rdy0"}, 32'(req0_ready), 0);
    chk({tag, "_exec_rdy1"}, 32'(req1_ready), 0);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    // Competing traffic during RESP must not be accepted, even in the handshake cycle.
    req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom);
    req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom);
    #1;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) rsp_ready = 1'b1;
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
      chk({tag, "_rsp_z"}, 32'(rsp_z), 32'(ez));
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(w));
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(eerr));
      chk({tag, "_rsp_rdy0"}, 32'(req0_ready), 0);
      chk({tag, "_rsp_rdy1"}, 32'(req1_ready), 0);
      if (i < stall) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 0);
  endtask

  task automatic contention();
    int w;
    req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h11; req0_op = 4'd1;
    req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h0F; req1_op = 4'd2;
    rsp_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = pick(1'b1, 1'b1);
      chk("cont_rdy0", 32'(req0_ready), 32'(w == 0));
      chk("cont_rdy1", 32'(req1_ready), 32'(w == 1));
      mptr = (w == 0);
      @(posedge clk); #1;
      chk("cont_exec_rdy0", 32'(req0_ready), 0);
      chk("cont_exec_valid", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      chk("cont_rsp_valid", 32'(rsp_valid), 1);
      chk("cont_rsp_id", 32'(rsp_id), 32'(w));
      chk("cont_rsp_z", 32'(rsp_z), (w == 0) ? 32'h22 : 32'h0C);
      chk("cont_rsp_rdy0", 32'(req0_ready), 0);
      chk("cont_rsp_rdy1", 32'(req1_ready), 0);
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("cont_idle_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    int v0, v1;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready  = 1'b0;
    #3;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_z", 32'(rsp_z), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_rdy0", 32'(req0_ready), 0);
    chk("rst_rdy1", 32'(req1_ready), 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    mptr = 1'b0;

    txn("single", 1'b1, 'h40, 'h03, 0, 1'b0, 0, 0, 0, 0);
    txn("illegal", 1'b0, 0, 0, 0, 1'b1, 'hFF, 'h07, 'hC, 0);
    contention();
    txn("bkpr", 1'b1, 'h5A, 'h21, 1, 1'b0, 0, 0, 0, 5);

    // Reset pulsed while the operation sits in EXEC.
    req0_valid = 1'b1; req0_a = 8'h77; req0_b = 8'h05; req0_op = 4'd0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_z", 32'(rsp_z), 0);
    chk("midrst_id", 32'(rsp_id), 0);
    chk("midrst_err", 32'(rsp_err), 0);
    chk("midrst_rdy0", 32'(req0_ready), 0);
    chk("midrst_rdy1", 32'(req1_ready), 0);
    #2;
    rst  = 1'b0;
    mptr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    txn("post_rst", 1'b1, 'h12, 'h0B, 8, 1'b0, 0, 0, 0, 0);

    for (int op = 0; op <= 8; op++) begin
      for (int b = 0; b < 8; b++) begin
        for (int a = 'h40; a <= 'hFF; a += 'h0F) begin
          txn("sweep", 1'b1, a, b, op, 1'b0, 0, 0, 0, 0);
        end
        txn("sweep", 1'b1, 'hFF, b, op, 1'b0, 0, 0, 0, 0);
      end
    end

    for (int n = 0; n < 60; n++) begin
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      if (v0 == 0 && v1 == 0) v0 = 1;
      txn("rand", v0[0], int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 15)), v1[0], int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
